// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto a TOP..0 down-counter stream, flags broken steps, counts errors and wraps (SEQ_CHK_STICKY_EN holds err until reset)
module count_seq_checker #(
  parameter int WIDTH    = 5,
  parameter int TOP      = 24,
  parameter int LOCK_CNT = 3
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [7:0]       wrap_cnt,
  output logic [WIDTH-1:0] expected
);
  typedef enum logic {HUNT, LOCK} state_t;
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  state_t r_state, w_state;
  logic [WIDTH-1:0] r_prev, r_exp, w_nxt_prev, w_nxt_q;
  logic r_prev_vld, r_err, w_err, w_legal, w_step_ok, w_mis, w_wrap;
  logic [3:0] r_match, w_match;
  logic [7:0] r_err_cnt, r_wrap_cnt;
  always_comb begin
    w_legal    = q_in <= TOP_V;
    w_nxt_prev = (r_prev == '0) ? TOP_V : r_prev - 1'b1;
    w_nxt_q    = (q_in == '0) ? TOP_V : q_in - 1'b1;
    w_step_ok  = r_prev_vld & w_legal & (q_in == w_nxt_prev);
    w_mis      = en & (r_state == LOCK) & ~w_step_ok;
    w_wrap     = en & (r_state == LOCK) & w_step_ok & (r_prev == '0) & (q_in == TOP_V);
    w_state    = r_state;
    if (en) w_state = (w_step_ok && (r_state == LOCK || r_match == LOCK_LAST)) ? LOCK : HUNT;
    w_match    = !en ? r_match : (r_state == HUNT && w_step_ok && r_match != LOCK_LAST) ? r_match + 4'd1 : 4'd0;
`ifdef SEQ_CHK_STICKY_EN
    w_err      = r_err | w_mis;
`else
    w_err      = w_mis;
`endif
  end
  always_ff @(posedge ck) begin
    if (rs) begin
      r_state    <= HUNT;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_match    <= 4'd0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_wrap_cnt <= 8'd0;
      r_exp      <= TOP_V;
    end else begin
      r_state <= w_state;
      r_match <= w_match;
      r_err   <= w_err;
      if (w_mis && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_wrap) r_wrap_cnt <= r_wrap_cnt + 8'd1;
      if (en) begin
        r_prev     <= q_in;
        r_prev_vld <= 1'b1;
        r_exp      <= w_legal ? w_nxt_q : TOP_V;
      end
    end
  end
  assign locked   = r_state == LOCK;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign wrap_cnt = r_wrap_cnt;
  assign expected = r_exp;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed and randomized checks of count_seq_checker against a run-length reference model
module tb_count_seq_checker;
  localparam int WIDTH = 5, TOP = 24, LOCK_CNT = 3;
  logic ck = 1'b0, rs = 1'b0, en = 1'b0;
  logic [WIDTH-1:0] q_in = '0;
  logic locked, err;
  logic [7:0] err_cnt, wrap_cnt;
  logic [WIDTH-1:0] expected;
  int n_pass = 0, n_total = 0;
  int m_prev, m_run, m_err_cnt, m_wrap, m_exp;
  bit m_vld, m_locked, m_err;
  count_seq_checker #(.WIDTH(WIDTH), .TOP(TOP), .LOCK_CNT(LOCK_CNT)) dut (
    .ck(ck), .rs(rs), .en(en), .q_in(q_in), .locked(locked), .err(err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .expected(expected)
  );
  always #5 ck = ~ck;
  function automatic int nxt(int v);
    return (v == 0) ? TOP : v - 1;
  endfunction
  task automatic model_reset();
    m_prev = 0; m_run = 0; m_err_cnt = 0; m_wrap = 0; m_exp = TOP;
    m_vld = 0; m_locked = 0; m_err = 0;
  endtask
  task automatic model_edge(bit e, int v);
    bit ok, mis;
    if (!e) begin
`ifndef SEQ_CHK_STICKY_EN
      m_err = 0;
`endif
      return;
    end
    ok  = m_vld && v <= TOP && v == nxt(m_prev);
    mis = m_locked && !ok;
`ifdef SEQ_CHK_STICKY_EN
    m_err = m_err | mis;
`else
    m_err = mis;
`endif
    if (mis) begin
      m_locked = 0; m_run = 0;
      if (m_err_cnt < 255) m_err_cnt++;
    end else if (m_locked) begin
      if (m_prev == 0 && v == TOP) m_wrap = (m_wrap + 1) % 256;
    end else if (ok) begin
      m_run++;
      if (m_run == LOCK_CNT) begin m_locked = 1; m_run = 0; end
    end else m_run = 0;
    m_prev = v; m_vld = 1;
    m_exp = (v <= TOP) ? nxt(v) : TOP;
  endtask
  task automatic drive(bit e, int v);
    en = e; q_in = WIDTH'(v);
    @(posedge ck); #1;
    model_edge(e, v);
  endtask
  task automatic test_reset();
    rs = 1; en = 1; q_in = 5'd10;
    @(posedge ck); #1;
    rs = 0; model_reset();
    n_total++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (wrap_cnt !== 8'd0) $display("FAIL reset_wrap_cnt got %0d want 0", wrap_cnt); else n_pass++;
    n_total++; if (expected !== 5'd24) $display("FAIL reset_expected got %0d want 24", expected); else n_pass++;
  endtask
  task automatic test_lock();
    drive(1, 24); drive(1, 23); drive(1, 22);
    n_total++; if (locked !== 1'b0) $display("FAIL lock_early got %0b want 0", locked); else n_pass++;
    drive(1, 21);
    n_total++; if (locked !== 1'b1) $display("FAIL lock_locked got %0b want 1", locked); else n_pass++;
    n_total++; if (expected !== 5'd20) $display("FAIL lock_expected got %0d want 20", expected); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL lock_err got %0b want 0", err); else n_pass++;
  endtask
  task automatic test_wrap();
    int w0;
    for (int v = 20; v >= 3; v--) drive(1, v);
    w0 = m_wrap;
    drive(1, 2); drive(1, 1); drive(1, 0);
    n_total++; if (wrap_cnt !== 8'(w0)) $display("FAIL wrap_before got %0d want %0d", wrap_cnt, w0); else n_pass++;
    drive(1, 24);
    n_total++; if (wrap_cnt !== 8'(w0 + 1)) $display("FAIL wrap_after got %0d want %0d", wrap_cnt, w0 + 1); else n_pass++;
    drive(1, 23);
    n_total++; if (err !== 1'b0) $display("FAIL wrap_err got %0b want 0", err); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL wrap_locked got %0b want 1", locked); else n_pass++;
  endtask
  task automatic test_source_reset();
    for (int v = 22; v >= 10; v--) drive(1, v);
    drive(1, 24);
    n_total++; if (err !== 1'b1) $display("FAIL srst_err got %0b want 1", err); else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL srst_err_cnt got %0d want 1", err_cnt); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL srst_locked got %0b want 0", locked); else n_pass++;
    drive(1, 23);
    n_total++; if (err !== m_err) $display("FAIL srst_err_next got %0b want %0b", err, m_err); else n_pass++;
    drive(1, 22); drive(1, 21);
    n_total++; if (locked !== 1'b1) $display("FAIL srst_relock got %0b want 1", locked); else n_pass++;
  endtask
  task automatic test_illegal();
    drive(1, 30);
    n_total++; if (err !== 1'b1) $display("FAIL ill_err got %0b want 1", err); else n_pass++;
    n_total++; if (err_cnt !== 8'd2) $display("FAIL ill_err_cnt got %0d want 2", err_cnt); else n_pass++;
    n_total++; if (expected !== 5'd24) $display("FAIL ill_expected got %0d want 24", expected); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL ill_locked got %0b want 0", locked); else n_pass++;
    drive(1, 24); drive(1, 23); drive(1, 22); drive(1, 21);
    n_total++; if (locked !== 1'b1) $display("FAIL ill_relock got %0b want 1", locked); else n_pass++;
  endtask
  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      drive(0, $urandom_range(0, 31));
      n_total++; if (locked !== 1'b1) $display("FAIL hold_locked got %0b want 1", locked); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL hold_err got %0b want %0b", err, m_err); else n_pass++;
      n_total++; if (err_cnt !== 8'(m_err_cnt)) $display("FAIL hold_err_cnt got %0d want %0d", err_cnt, m_err_cnt); else n_pass++;
      n_total++; if (wrap_cnt !== 8'(m_wrap)) $display("FAIL hold_wrap_cnt got %0d want %0d", wrap_cnt, m_wrap); else n_pass++;
      n_total++; if (expected !== 5'd20) $display("FAIL hold_expected got %0d want 20", expected); else n_pass++;
    end
    drive(1, 20);
    n_total++; if (locked !== 1'b1) $display("FAIL hold_resume_locked got %0b want 1", locked); else n_pass++;
    n_total++; if (err !== m_err) $display("FAIL hold_resume_err got %0b want %0b", err, m_err); else n_pass++;
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      drive(1, m_prev);
      for (int k = 0; k < LOCK_CNT; k++) drive(1, nxt(m_prev));
    end
    n_total++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got %0d want 255", err_cnt); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL sat_locked got %0b want 1", locked); else n_pass++;
    n_total++; if (err !== m_err) $display("FAIL sat_err got %0b want %0b", err, m_err); else n_pass++;
  endtask
  task automatic test_random();
    bit e;
    int v;
    rs = 1; @(posedge ck); #1; rs = 0; model_reset();
    n_total++; if (err !== 1'b0) $display("FAIL rnd_reset_err got %0b want 0", err); else n_pass++;
    for (int i = 0; i < 600; i++) begin
      e = $urandom_range(0, 7) != 0;
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : nxt(m_prev);
      drive(e, v);
      n_total++; if (locked !== m_locked) $display("FAIL rnd_locked i=%0d got %0b want %0b", i, locked, m_locked); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL rnd_err i=%0d got %0b want %0b", i, err, m_err); else n_pass++;
      n_total++; if (err_cnt !== 8'(m_err_cnt)) $display("FAIL rnd_err_cnt i=%0d got %0d want %0d", i, err_cnt, m_err_cnt); else n_pass++;
      n_total++; if (wrap_cnt !== 8'(m_wrap)) $display("FAIL rnd_wrap_cnt i=%0d got %0d want %0d", i, wrap_cnt, m_wrap); else n_pass++;
      n_total++; if (expected !== WIDTH'(m_exp)) $display("FAIL rnd_expected i=%0d got %0d want %0d", i, expected, m_exp); else n_pass++;
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_source_reset();
    test_illegal();
    test_hold();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
